// File: rtl/dvi_tmds_encoder.sv
// DVI 1.0 TMDS encoder: three channels, each a two-stage pipeline
// (transition minimisation, then DC balancing with a running disparity count).

module dvi_tmds_channel (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] d_i,
   input  logic       de_i,
   input  logic [1:0] c_i,
   output logic [9:0] sym_o
);
   localparam logic [9:0] TOKEN_00 = 10'b1101010100;
   localparam logic [9:0] TOKEN_01 = 10'b0010101011;
   localparam logic [9:0] TOKEN_10 = 10'b0101010100;
   localparam logic [9:0] TOKEN_11 = 10'b1010101011;

   logic [7:0]        d_q;
   logic [1:0]        de_pipe_q;
   logic [1:0]        c1_q, c2_q;
   logic [8:0]        qm_d, qm_q;
   logic [9:0]        sym_d, sym_q;
   logic signed [4:0] cnt_d, cnt_q;
   logic [3:0]        n1d, n1q;
   logic              xnor_mode;
   logic signed [4:0] dq;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         d_q       <= '0;
         de_pipe_q <= '0;
         c1_q      <= '0;
         c2_q      <= '0;
         qm_q      <= '0;
         sym_q     <= TOKEN_00;
         cnt_q     <= '0;
      end else begin
         d_q       <= d_i;
         de_pipe_q <= {de_pipe_q[0], de_i};
         c1_q      <= c_i;
         c2_q      <= c1_q;
         qm_q      <= qm_d;
         sym_q     <= sym_d;
         cnt_q     <= cnt_d;
      end
   end

   assign n1d       = 4'($countones(d_q));
   assign xnor_mode = (n1d > 4'd4) || ((n1d == 4'd4) && !d_q[0]);

   always_comb begin
      qm_d    = '0;
      qm_d[0] = d_q[0];
      for (int i = 1; i < 8; i++)
         qm_d[i] = xnor_mode ? ~(qm_d[i-1] ^ d_q[i]) : (qm_d[i-1] ^ d_q[i]);
      qm_d[8] = ~xnor_mode;
   end

   // dq = n1q - n0q = 2*n1q - 8, kept in the same signed 5-bit domain as cnt
   assign n1q = 4'($countones(qm_q[7:0]));
   assign dq  = $signed({n1q, 1'b0} - 5'd8);

   always_comb begin
      sym_d = TOKEN_00;
      cnt_d = '0;
      if (!de_pipe_q[1]) begin
         case (c2_q)
            2'b00:   sym_d = TOKEN_00;
            2'b01:   sym_d = TOKEN_01;
            2'b10:   sym_d = TOKEN_10;
            default: sym_d = TOKEN_11;
         endcase
      end else if ((cnt_q == 5'sd0) || (dq == 5'sd0)) begin
         sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
         cnt_d = qm_q[8] ? (cnt_q + dq) : (cnt_q - dq);
      end else if (((cnt_q > 5'sd0) && (dq > 5'sd0)) || ((cnt_q < 5'sd0) && (dq < 5'sd0))) begin
         sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
         cnt_d = cnt_q + (qm_q[8] ? 5'sd2 : 5'sd0) - dq;
      end else begin
         sym_d = {1'b0, qm_q[8], qm_q[7:0]};
         cnt_d = cnt_q - (qm_q[8] ? 5'sd0 : 5'sd2) + dq;
      end
   end

   assign sym_o = sym_q;
endmodule

module dvi_tmds_encoder #(
   parameter int RED_LSB   = 0,
   parameter int GREEN_LSB = 8,
   parameter int BLUE_LSB  = 16
) (
   input  logic        dvi_clk,
   input  logic        reset,
   input  logic [31:0] dvi_rgb,
   input  logic        dvi_hsync,
   input  logic        dvi_vsync,
   input  logic        dvi_active_video,
   output logic [9:0]  tmds_ch0,
   output logic [9:0]  tmds_ch1,
   output logic [9:0]  tmds_ch2
);
   localparam int NUM_CH = 3;

   logic [NUM_CH-1:0][7:0] comp;
   logic [NUM_CH-1:0][1:0] ctrl;
   logic [NUM_CH-1:0][9:0] sym;
   logic                   unused_rgb;

   // ch0 = blue carries the syncs; green and red only ever send C=00
   assign comp[0] = dvi_rgb[BLUE_LSB +: 8];
   assign comp[1] = dvi_rgb[GREEN_LSB +: 8];
   assign comp[2] = dvi_rgb[RED_LSB +: 8];
   assign ctrl[0] = {dvi_vsync, dvi_hsync};
   assign ctrl[1] = 2'b00;
   assign ctrl[2] = 2'b00;
   assign unused_rgb = ^dvi_rgb[31:24];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      dvi_tmds_channel u_ch (
         .clk_i (dvi_clk),
         .rst_i (reset),
         .d_i   (comp[g]),
         .de_i  (dvi_active_video),
         .c_i   (ctrl[g]),
         .sym_o (sym[g])
      );
   end

   assign tmds_ch0 = sym[0];
   assign tmds_ch1 = sym[1];
   assign tmds_ch2 = sym[2];
endmodule
